data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressed, little-endian data memory for the MEM stage of the RV32I pipeline.
- Executes loads and stores of byte, halfword and word width, selected by the instruction funct3.
- Stores are synchronous on the rising clock edge.
- Loads are combinational, so load data reaches MEM/WB within the same cycle.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, minimum 4.
- ADDR_LSB_W, derived as log2(DEPTH_WORDS)+2: number of address bits actually decoded.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- mem_write  input  1  store enable, sampled at posedge clk.
- mem_read  input  1  load enable; combinational.
- funct3  input  3  access width/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  input  32  byte address.
- write_data  input  32  store data; the low byte/halfword is used for SB/SH.
- read_data  output  32  load result, sign- or zero-extended.

Behaviour:
- Storage: DEPTH_WORDS x 32-bit array.
  - Word index = addr[ADDR_LSB_W-1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- Reset: rst_n low immediately clears every word to 0 and forces read_data = 0, independent of clk. Stores are blocked while rst_n is low.
- Store (posedge clk, rst_n high, mem_write=1):
  - SB: write_data[7:0] goes to byte lane addr[1:0].
  - SH: write_data[15:0] goes to lanes {addr[1],0}; addr[0] is ignored.
  - SW: full word is written; addr[1:0] are ignored.
  - Unwritten byte lanes keep their contents.
  - Any other funct3 (011, 110, 111) writes nothing.
- Load (combinational, mem_read=1):
  - LB: selected byte, sign-extended.
  - LBU: selected byte, zero-extended.
  - LH: selected halfword, sign-extended.
  - LHU: selected halfword, zero-extended.
  - LW: full word.
  - Byte and halfword lanes are selected the same way as for stores.
  - Any other funct3 returns 0.
- mem_read=0 -> read_data=0.
- Simultaneous read and write to the same address:
  - read_data shows the old contents until the clock edge.
  - It shows the new contents immediately after the edge, with no bypass.
- Latency: store is visible 0 cycles after the writing edge; load has 0-cycle latency.

Optional Feature:
- Macro: DATA_MEMORY_MISALIGN_CHECK_EN.
- When defined:
  - Adds output port misaligned (1 bit).
  - misaligned is asserted combinationally when (mem_read|mem_write) and either:
    - funct3 selects a halfword and addr[0]=1, or
    - funct3 selects a word and addr[1:0]!=0.
  - While misaligned is high, stores are suppressed and read_data=0.
  - misaligned=0 during reset.
- When undefined: no port, and low address bits are ignored as described above.

Decomposition:
- Shared package dmem_pkg holds the funct3 constants:
  - F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One sub-module, dmem_load_align: pure combinational lane select plus sign/zero extension, taking (word, addr[1:0], funct3) and producing read_data.

Test Plan:
- SW 0x11223344 at addr 0, then LW at addr 0 -> 0x11223344.
- SB 0xAB at addr 5 over word 0 at addr 4:
  - LW addr 4 -> 0x0000AB00.
  - LB addr 5 -> 0xFFFFFFAB.
  - LBU addr 5 -> 0x000000AB.
- SH 0x8001 at addr 10:
  - LH addr 10 -> 0xFFFF8001.
  - LHU addr 10 -> 0x00008001.
  - LW addr 8 -> 0x80010000.
- Reset mid-run after SW 0xDEADBEEF at addr 12: pulse rst_n low, then LW addr 12 -> 0. read_data=0 throughout the low pulse, including with mem_read=1.
- Wrap and invalid funct3:
  - SW 0xCAFEF00D at addr 4*DEPTH_WORDS, then LW addr 0 -> 0xCAFEF00D.
  - Store with funct3=011 changes nothing.
  - mem_read=0 -> read_data=0.
- Same-cycle read and write: LW addr 16 holds old value 0 before the edge; SW 0x55 at addr 16 shows 0x00000055 after the edge. With DATA_MEMORY_MISALIGN_CHECK_EN: SW at addr 2 -> misaligned=1 and memory is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings shared by the data memory and its load aligner
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: MEM-stage load/store bus; misaligned exists only with DATA_MEMORY_MISALIGN_CHECK_EN
interface data_memory_if;
  logic        mem_write;
  logic        mem_read;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  logic        misaligned;
  modport master (output mem_write, mem_read, funct3, addr, write_data, input read_data, misaligned);
  modport slave  (input mem_write, mem_read, funct3, addr, write_data, output read_data, misaligned);
`else
  modport master (output mem_write, mem_read, funct3, addr, write_data, input read_data);
  modport slave  (input mem_write, mem_read, funct3, addr, write_data, output read_data);
`endif
endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the byte/halfword lane of a word and sign- or zero-extends it
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lsb,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // Lane select then extension; unknown funct3 yields zero
  always_comb begin
    b = word[8*lsb +: 8];
    h = lsb[1] ? word[31:16] : word[15:0];
    data = funct3 == F3_B  ? {{24{b[7]}}, b} :
           funct3 == F3_BU ? {24'b0, b} :
           funct3 == F3_H  ? {{16{h[15]}}, h} :
           funct3 == F3_HU ? {16'b0, h} :
           funct3 == F3_W  ? word : 32'b0;
  end
endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressed little-endian RV32I data memory; optional DATA_MEMORY_MISALIGN_CHECK_EN
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);
  localparam int ADDR_LSB_W = $clog2(DEPTH_WORDS) + 2;
  logic [31:0] mem [DEPTH_WORDS];
  logic [ADDR_LSB_W-3:0] idx;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] ld;
  logic        mis;
  logic        we;
  logic        unused_addr;
  assign idx = bus.addr[ADDR_LSB_W-1:2];
  assign unused_addr = ^bus.addr[31:ADDR_LSB_W];
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  assign mis = (bus.mem_read | bus.mem_write) &
               ((((bus.funct3 == F3_H) | (bus.funct3 == F3_HU)) & bus.addr[0]) |
                ((bus.funct3 == F3_W) & (bus.addr[1:0] != 2'b00)));
  assign bus.misaligned = rst_n & mis;
`else
  assign mis = 1'b0;
`endif
  assign we = bus.mem_write & ~mis;
  // Store lane enables and lane-replicated store data
  always_comb begin
    be = bus.funct3 == F3_B ? 4'b0001 << bus.addr[1:0] :
         bus.funct3 == F3_H ? (bus.addr[1] ? 4'b1100 : 4'b0011) :
         bus.funct3 == F3_W ? 4'b1111 : 4'b0000;
    wd = bus.funct3 == F3_B ? {4{bus.write_data[7:0]}} :
         bus.funct3 == F3_H ? {2{bus.write_data[15:0]}} : bus.write_data;
  end
  // Asynchronous clear of the whole array; byte-masked store on the clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < 4; i++) if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end
  dmem_load_align u_align (
    .word   (mem[idx]),
    .lsb    (bus.addr[1:0]),
    .funct3 (bus.funct3),
    .data   (ld)
  );
  assign bus.read_data = (rst_n & bus.mem_read & ~mis) ? ld : 32'b0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: byte-array reference model plus directed load/store vectors
module tb_data_memory;
  import dmem_pkg::*;
  localparam int D  = 256;
  localparam int NB = 4 * D;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  data_memory_if bus ();
  data_memory #(.DEPTH_WORDS(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] m [NB];
  int vectors = 0;
  int errors = 0;
  bit run = 1'b0;

  function automatic bit is_mis(input logic [2:0] f, input logic [31:0] a);
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
    return (((f == F3_H) || (f == F3_HU)) && a[0]) || ((f == F3_W) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic rn, input logic rd, input logic [2:0] f, input logic [31:0] a);
    int ba, v;
    ba = int'(a % 32'(NB));
    if (!rn || !rd || is_mis(f, a)) return 32'b0;
    case (f)
      F3_B, F3_BU: begin
        v = int'(m[ba]);
        if (f == F3_B && v >= 128) v -= 256;
        return 32'(v);
      end
      F3_H, F3_HU: begin
        ba = ba - ba % 2;
        v = int'(m[ba]) + 256 * int'(m[ba+1]);
        if (f == F3_H && v >= 32768) v -= 65536;
        return 32'(v);
      end
      F3_W: begin
        ba = ba - ba % 4;
        return {m[ba+3], m[ba+2], m[ba+1], m[ba]};
      end
      default: return 32'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) m[i] <= 8'h00;
    end else if (bus.mem_write && !is_mis(bus.funct3, bus.addr)) begin
      int ba;
      ba = int'(bus.addr % 32'(NB));
      case (bus.funct3)
        F3_B: m[ba] <= bus.write_data[7:0];
        F3_H: for (int k = 0; k < 2; k++) m[ba - ba % 2 + k] <= bus.write_data[8*k +: 8];
        F3_W: for (int k = 0; k < 4; k++) m[ba - ba % 4 + k] <= bus.write_data[8*k +: 8];
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [31:0] e;
      e = model_read(rst_n, bus.mem_read, bus.funct3, bus.addr);
      vectors++;
      if (bus.read_data !== e) begin
        errors++;
        $display("FAIL model_rd addr=%h f3=%b got %h want %h", bus.addr, bus.funct3, bus.read_data, e);
      end
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
      vectors++;
      if (bus.misaligned !== (rst_n && (bus.mem_read || bus.mem_write) && is_mis(bus.funct3, bus.addr))) begin
        errors++;
        $display("FAIL model_mis got %b", bus.misaligned);
      end
`endif
    end
  end

  task automatic drive(input logic w, input logic r, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.mem_write = w;
    bus.mem_read = r;
    bus.funct3 = f;
    bus.addr = a;
    bus.write_data = d;
  endtask

  task automatic lit(input string n, input logic [31:0] e);
    #1;
    vectors++;
    if (bus.read_data !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, bus.read_data, e);
    end
  endtask

  initial begin
    bus.mem_write = 1'b0;
    bus.mem_read = 1'b1;
    bus.funct3 = F3_W;
    bus.addr = 32'd0;
    bus.write_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    lit("reset_rd", 32'h0);
    #2 rst_n = 1'b1;
    drive(1, 0, F3_W, 0, 32'h11223344);
    drive(0, 1, F3_W, 0, 0);          lit("lw0", 32'h11223344);
    drive(1, 0, F3_B, 5, 32'h000000AB);
    drive(0, 1, F3_W, 4, 0);          lit("lw4", 32'h0000AB00);
    drive(0, 1, F3_B, 5, 0);          lit("lb5", 32'hFFFFFFAB);
    drive(0, 1, F3_BU, 5, 0);         lit("lbu5", 32'h000000AB);
    drive(1, 0, F3_H, 10, 32'h12348001);
    drive(0, 1, F3_H, 10, 0);         lit("lh10", 32'hFFFF8001);
    drive(0, 1, F3_HU, 10, 0);        lit("lhu10", 32'h00008001);
    drive(0, 1, F3_W, 8, 0);          lit("lw8", 32'h80010000);
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
    drive(0, 1, F3_H, 11, 0);         lit("lh11", 32'h0);
`else
    drive(0, 1, F3_H, 11, 0);         lit("lh11", 32'hFFFF8001);
`endif
    for (int i = 0; i < 4; i++) drive(1, 0, F3_B, 20 + i, 32'h10 + i);
    drive(0, 1, F3_W, 20, 0);         lit("lanes", 32'h13121110);
    drive(1, 0, F3_W, 12, 32'hDEADBEEF);
    drive(0, 1, F3_W, 12, 0);         lit("lw12", 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    lit("rst_async", 32'h0);
    drive(1, 1, F3_W, 12, 32'h12345678);
    lit("rst_hold", 32'h0);
    @(posedge clk);
    #2 bus.mem_write = 1'b0;
    #1 rst_n = 1'b1;
    lit("after_rst", 32'h0);
    drive(0, 1, F3_W, 0, 0);          lit("cleared0", 32'h0);
    drive(1, 0, F3_W, NB, 32'hCAFEF00D);
    drive(0, 1, F3_W, 0, 0);          lit("wrap", 32'hCAFEF00D);
    drive(1, 0, 3'b011, 0, 32'hFFFFFFFF);
    drive(0, 1, F3_W, 0, 0);          lit("bad_store", 32'hCAFEF00D);
    drive(0, 0, F3_W, 0, 0);          lit("no_read", 32'h0);
    drive(0, 1, 3'b011, 0, 0);        lit("bad_load", 32'h0);
    drive(1, 1, F3_W, 16, 32'h55);    lit("same_old", 32'h0);
    @(posedge clk);
    #1 bus.mem_write = 1'b0;
    lit("same_new", 32'h00000055);
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
    drive(1, 0, F3_W, 2, 32'hFFFFFFFF);
    #1;
    vectors++;
    if (bus.misaligned !== 1'b1) begin
      errors++;
      $display("FAIL mis_sw2 got %b want 1", bus.misaligned);
    end
    drive(0, 1, F3_W, 0, 0);          lit("mis_nowrite", 32'hCAFEF00D);
`else
    drive(1, 0, F3_W, 2, 32'h01020304);
    drive(0, 1, F3_W, 0, 0);          lit("sw2_aligned", 32'h01020304);
`endif
    drive(0, 0, F3_W, 0, 0);
    @(posedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
